arbiter_rr_onehot: RTL and testbench



---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_rr_priority_pick.sv | 37 +++
 rtl/arbiter_rr_onehot.sv | 131 +++++++++++++
 tb/tb_arbiter_rr_onehot.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and width helpers for the round-robin arbiter
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for N requesters, never narrower than one bit.
    function automatic int arb_iw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Hold-counter width; it only has to count up to MAX_HOLD-1.
    function automatic int arb_cw(input int max_hold);
        return (max_hold <= 2) ? 1 : $clog2(max_hold);
    endfunction

endpackage

// File: rtl/arb_rr_priority_pick.sv
// rtl/arb_rr_priority_pick.sv - circular first-set-bit pick starting at ptr
module arb_rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = arb_iw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_id,
    output logic          found
);

    logic [N-1:0] mask;
    logic [N-1:0] masked_req;
    logic [N-1:0] scan_src;

    // Requests at or above ptr win first; otherwise fall back to the unmasked set.
    assign mask       = {N{1'b1}} << ptr;
    assign masked_req = req & mask;
    assign scan_src   = (|masked_req) ? masked_req : req;

    // Isolate the lowest set bit through the carry chain of a two's complement.
    assign pick  = scan_src & (~scan_src + 1'b1);
    assign found = |req;

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                pick_id = pick_id | IW'(i);
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_onehot.sv
// rtl/arbiter_rr_onehot.sv - registered one-hot round-robin arbiter with hold-until-ack
// Optional forced release after MAX_HOLD cycles when ARB_RR_TIMEOUT_EN is defined.
module arbiter_rr_onehot
    import arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    input  logic                 grant_ack,
    output logic                 grant_valid,
    output logic [N-1:0]         grant,
    output logic [arb_iw(N)-1:0] grant_id,
    output logic                 grant_timeout
);

    localparam int IW = arb_iw(N);

    arb_state_e    state_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] grant_id_q;
    logic          grant_valid_q;
    logic          grant_timeout_q;
    logic [IW-1:0] ptr_q;

    logic [IW-1:0] ptr_d;
    logic [N-1:0]  pick_req;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_id;
    logic          found;
    logic          forced_release;
    logic          release_grant;

    // On release the just-served client is masked out and the scan restarts above it.
    always_comb begin
        ptr_d    = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1;
        pick_req = request;
        pick_ptr = ptr_q;
        if (state_q == GRANT) begin
            pick_req = request & ~grant_q;
            pick_ptr = ptr_d;
        end
    end

    arb_rr_priority_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .found   (found)
    );

`ifdef ARB_RR_TIMEOUT_EN
    localparam int CW = arb_cw(MAX_HOLD);

    logic [CW-1:0] hold_q;

    assign forced_release = (state_q == GRANT) && !grant_ack
                            && (hold_q == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (state_q != GRANT || release_grant) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + 1'b1;
        end
    end
`else
    logic unused_max_hold;

    assign unused_max_hold = (MAX_HOLD > 0);
    assign forced_release  = 1'b0;
`endif

    assign release_grant = grant_ack | forced_release;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            grant_id_q      <= '0;
            grant_valid_q   <= 1'b0;
            grant_timeout_q <= 1'b0;
            ptr_q           <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_timeout_q <= 1'b0;
                    if (found) begin
                        grant_q       <= pick;
                        grant_id_q    <= pick_id;
                        grant_valid_q <= 1'b1;
                        state_q       <= GRANT;
                    end
                end
                GRANT: begin
                    grant_timeout_q <= forced_release;
                    if (release_grant) begin
                        ptr_q <= ptr_d;
                        if (found) begin
                            grant_q    <= pick;
                            grant_id_q <= pick_id;
                        end else begin
                            grant_q       <= '0;
                            grant_id_q    <= '0;
                            grant_valid_q <= 1'b0;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign grant_id      = grant_id_q;
    assign grant_valid   = grant_valid_q;
    assign grant_timeout = grant_timeout_q;

endmodule

// File: tb/tb_arbiter_rr_onehot.sv
// tb/tb_arbiter_rr_onehot.sv - self-checking bench for arbiter_rr_onehot against a scan model
module tb_arbiter_rr_onehot;

    localparam int N        = 8;
    localparam int IW       = 3;
    localparam int MAX_HOLD = 4;
`ifdef ARB_RR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int VW = N + IW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  request = '0;
    logic          grant_ack = 1'b0;
    logic          grant_valid;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          grant_timeout;

    int checks = 0;
    int passed = 0;

    // Reference state: who holds the grant, where the circular scan starts, hold age.
    bit m_valid = 0;
    int m_id    = 0;
    int m_ptr   = 0;
    bit m_to    = 0;
    int m_hold  = 0;

    logic [VW-1:0] obs;
    logic [VW-1:0] expv;

    arbiter_rr_onehot #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request       (request),
        .grant_ack     (grant_ack),
        .grant_valid   (grant_valid),
        .grant         (grant),
        .grant_id      (grant_id),
        .grant_timeout (grant_timeout)
    );

    always #5 clk = ~clk;

    function automatic int scan(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0] g;
        logic [IW-1:0] id;
        g  = m_valid ? (N'(1) << m_id) : '0;
        id = IW'(m_id);
        return {m_to, m_valid, id, g};
    endfunction

    // Advance model and DUT by one edge; outputs are observed 1 time unit later.
    task automatic cycle();
        bit n_valid, n_to;
        int n_id, n_ptr, n_hold, w;
        bit rel, forced;
        n_valid = m_valid; n_id = m_id; n_ptr = m_ptr; n_to = 0; n_hold = m_hold;
        if (rst) begin
            n_valid = 0; n_id = 0; n_ptr = 0; n_hold = 0;
        end else if (!m_valid) begin
            w = scan(request, m_ptr);
            if (w >= 0) begin n_valid = 1; n_id = w; n_hold = 0; end
        end else begin
            forced = TO_EN && !grant_ack && (m_hold == MAX_HOLD - 1);
            rel    = grant_ack || forced;
            n_to   = forced;
            if (rel) begin
                n_ptr = (m_id + 1) % N;
                w = scan(request & ~(N'(1) << m_id), n_ptr);
                n_hold = 0;
                if (w >= 0) n_id = w;
                else begin n_valid = 0; n_id = 0; end
            end else begin
                n_hold = m_hold + 1;
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_id = n_id; m_ptr = n_ptr; m_to = n_to; m_hold = n_hold;
        obs  = {grant_timeout, grant_valid, grant_id, grant};
        expv = model_vec();
    endtask

    task automatic do_reset();
        rst = 1'b1; request = '0; grant_ack = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; request = 8'h04;
        cycle();
        checks++;
        if (obs !== '0) $display("FAIL reset_outputs got=%h want=0", obs);
        else passed++;
        rst = 1'b0;
        cycle();
        checks++;
        if (grant !== 8'h04 || grant_id !== 3'd2 || grant_valid !== 1'b1)
            $display("FAIL single_request got=%h/%0d/%b want=04/2/1", grant, grant_id, grant_valid);
        else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        request = 8'hFF; grant_ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== IW'(i % N) || obs !== expv)
                $display("FAIL round_robin[%0d] got=%0d valid=%b want=%0d", i, grant_id, grant_valid, i % N);
            else passed++;
        end
        grant_ack = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        request = 8'h08;
        cycle();
        request = 8'h20;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (grant !== 8'h08 || obs !== expv)
                $display("FAIL hold[%0d] got=%h want=08", i, grant);
            else passed++;
        end
        grant_ack = 1'b1;
        cycle();
        grant_ack = 1'b0;
        checks++;
        if (grant !== 8'h20 || grant_id !== 3'd5 || obs !== expv)
            $display("FAIL hold_next got=%h/%0d want=20/5", grant, grant_id);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        request = 8'h80;
        cycle();
        request = 8'h81; grant_ack = 1'b1;
        cycle();
        checks++;
        if (grant_id !== 3'd0 || grant_valid !== 1'b1 || obs !== expv)
            $display("FAIL wrap_to_0 got=%0d/%b want=0/1", grant_id, grant_valid);
        else passed++;
        request = 8'h80;
        cycle();
        cycle();
        checks++;
        if (grant_valid !== 1'b0 || grant !== 8'h00 || obs !== expv)
            $display("FAIL exclude_gap got=%h/%b want=00/0", grant, grant_valid);
        else passed++;
        grant_ack = 1'b0;
        cycle();
        checks++;
        if (grant !== 8'h80 || grant_id !== 3'd7 || obs !== expv)
            $display("FAIL exclude_rewin got=%h/%0d want=80/7", grant, grant_id);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        request = 8'h10;
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (obs !== '0) $display("FAIL reset_mid got=%h want=0", obs);
        else passed++;
        rst = 1'b0; request = 8'h18;
        cycle();
        checks++;
        if (grant !== 8'h08 || grant_id !== 3'd3 || obs !== expv)
            $display("FAIL reset_mid_ptr got=%h/%0d want=08/3", grant, grant_id);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        request = 8'h02;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (obs !== expv || (TO_EN && i == 4 && grant_timeout !== 1'b1) ||
                ((!TO_EN || i != 4) && grant_timeout !== 1'b0))
                $display("FAIL timeout[%0d] got=%h want=%h", i, obs, expv);
            else passed++;
        end
        for (int i = 0; i < 5; i++) begin
            grant_ack = (i == 3);
            cycle();
            checks++;
            if (obs !== expv || grant_timeout !== 1'b0)
                $display("FAIL timeout_ack[%0d] got=%h want=%h", i, obs, expv);
            else passed++;
        end
        grant_ack = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            request   = N'($urandom) & N'($urandom);
            grant_ack = ($urandom_range(0, 2) == 0);
            cycle();
            checks++;
            if (obs !== expv) $display("FAIL random[%0d] got=%h want=%h", i, obs, expv);
            else passed++;
        end
        rst = 1'b0; grant_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
